// File: rtl/demux_pkg.sv
// demux_pkg: shared slot encoding, error-counter width and clog2 helper
package demux_pkg;
  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_e;
  localparam int ERR_CNT_W = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output register with EMPTY/FULL state and free/drain logic
module demux_slot
  import demux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         free
);
  slot_state_e state_q, state_d;
  always_ff @(posedge clock or negedge reset_)
    if (!reset_) begin
      state_q <= SLOT_EMPTY;
      data    <= '0;
    end else begin
      state_q <= state_d;
      if (wr) data <= wr_data;
    end
  always_comb begin
    state_d = state_q;
    state_d = wr ? SLOT_FULL : (ready ? SLOT_EMPTY : state_q);
  end
  assign valid = state_q == SLOT_FULL;
  assign free  = state_q == SLOT_EMPTY || ready;
endmodule

// File: rtl/demux_1ton_stream.sv
// demux_1ton_stream: 1-to-N valid/ready demultiplexer with broadcast and
// out-of-range drop counting
module demux_1ton_stream
  import demux_pkg::*;
#(
  parameter  int W     = 8,
  parameter  int N     = 16,
  localparam int SEL_W = (N > 1) ? clog2(N) : 1
) (
  input  logic                 clock,
  input  logic                 reset_,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_bcast,
  output logic [N-1:0]         out_valid,
  input  logic [N-1:0]         out_ready,
  output logic [N*W-1:0]       out_data,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);
  logic [N-1:0] sel_oh, free, wr;
  logic in_range, accept, drop;
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < N; i++) sel_oh[i] = 32'(in_sel) == 32'(i);
  end
  assign in_range = |sel_oh;
  // Out-of-range words are always consumed so they never stall the producer
  assign in_ready = in_bcast ? &free : (in_range ? |(sel_oh & free) : 1'b1);
  assign accept   = in_valid && in_ready;
  assign wr       = accept ? (in_bcast ? '1 : sel_oh) : '0;
  assign drop     = accept && !in_bcast && !in_range;
  for (genvar g = 0; g < N; g++) begin : g_slot
    demux_slot #(.W(W)) u_slot (
      .clock   (clock),
      .reset_  (reset_),
      .wr      (wr[g]),
      .wr_data (in_data),
      .ready   (out_ready[g]),
      .valid   (out_valid[g]),
      .data    (out_data[g*W +: W]),
      .free    (free[g])
    );
  end
  always_ff @(posedge clock or negedge reset_)
    if (!reset_) begin
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= drop;
      if (drop && err_count != '1) err_count <= err_count + 1'b1;
    end
endmodule

// File: tb/tb_demux_1ton_stream.sv
// tb_demux_1ton_stream: directed stimulus with per-channel scoreboard queues
// popped by an independent drain monitor
module tb_demux_1ton_stream;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_;
  logic v16, bc16, rdy16, err16;
  logic [7:0] d16, ec16;
  logic [3:0] sel16;
  logic [15:0] ov16, or16;
  logic [127:0] od16;
  logic v12, rdy12, err12;
  logic [3:0] sel12;
  logic [11:0] ov12;
  logic [95:0] od12;
  logic [7:0] ec12;
  int errors = 0, checks = 0;
  logic [7:0] q[16][$];

  demux_1ton_stream #(.W(8), .N(16)) u16 (
    .clock(clock), .reset_(reset_), .in_valid(v16), .in_ready(rdy16),
    .in_data(d16), .in_sel(sel16), .in_bcast(bc16), .out_valid(ov16),
    .out_ready(or16), .out_data(od16), .err(err16), .err_count(ec16)
  );
  demux_1ton_stream #(.W(8), .N(12)) u12 (
    .clock(clock), .reset_(reset_), .in_valid(v12), .in_ready(rdy12),
    .in_data(d16), .in_sel(sel12), .in_bcast(1'b0), .out_valid(ov12),
    .out_ready(12'h000), .out_data(od12), .err(err12), .err_count(ec12)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] s, input logic b, output int waits);
    bit got;
    d16 = d; sel16 = s; bc16 = b; v16 = 1'b1; waits = 0; got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clock);
      if (rdy16) got = 1;
      else waits++;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send timeout: got ready=0 expected 1");
    end else if (b) begin
      for (int i = 0; i < 16; i++) q[i].push_back(d);
    end else q[s].push_back(d);
    @(posedge clock); #1;
    v16 = 1'b0; bc16 = 1'b0;
  endtask

  always @(negedge clock)
    if (reset_ === 1'b1)
      for (int i = 0; i < 16; i++)
        if (ov16[i] && or16[i]) begin
          checks++;
          if (q[i].size() == 0) begin
            errors++;
            $display("FAIL mon ch%0d: got %0h expected no word", i, od16[i*8 +: 8]);
          end else begin
            logic [7:0] e;
            e = q[i].pop_front();
            if (od16[i*8 +: 8] !== e) begin
              errors++;
              $display("FAIL mon ch%0d: got %0h expected %0h", i, od16[i*8 +: 8], e);
            end
          end
        end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w, tot;
    reset_ = 1'b0;
    v16 = 1'($urandom); bc16 = 1'($urandom); d16 = 8'($urandom); sel16 = 4'($urandom);
    or16 = 16'($urandom); v12 = 1'($urandom); sel12 = 4'($urandom);
    #23;
    chk("rst out_valid", ov16, 0);
    chk("rst out_data", od16, 0);
    chk("rst err", err16, 0);
    chk("rst err_count", ec16, 0);
    chk("rst err_count n12", ec12, 0);
    @(posedge clock); #1;
    v16 = 0; bc16 = 0; or16 = 0; v12 = 0; sel16 = 5;
    reset_ = 1'b1;
    #1 chk("t1 ready sel5", rdy16, 1);
    // single word held by a stalled consumer
    send(8'hA5, 3, 0, w);
    chk("t2 out_valid", ov16, 16'h0008);
    chk("t2 data", od16[31:24], 8'hA5);
    d16 = 8'h5A; sel16 = 3; v16 = 1;
    #1 chk("t2 stall ready", rdy16, 0);
    @(posedge clock); #1;
    chk("t2 hold valid", ov16, 16'h0008);
    chk("t2 hold data", od16[31:24], 8'hA5);
    or16 = 16'h0008;
    #1 chk("t2 ready on drain", rdy16, 1);
    send(8'h5A, 3, 0, w);
    chk("t2 waits", w, 0);
    // back-to-back stream into a draining slot
    for (int k = 1; k <= 4; k++) begin
      send(8'(k), 3, 0, w);
      chk("t3 waits", w, 0);
      chk("t3 data", od16[31:24], 128'(k));
      chk("t3 valid", ov16, 16'h0008);
    end
    or16 = '1;
    repeat (2) @(posedge clock);
    #1 chk("t3 drained", ov16, 0);
    // broadcast blocked by one full slot
    or16 = 0;
    send(8'h77, 7, 0, w);
    chk("t4 slot7 full", ov16, 16'h0080);
    d16 = 8'h3C; bc16 = 1; v16 = 1;
    #1 chk("t4 bcast ready", rdy16, 0);
    @(posedge clock); #1;
    chk("t4 no partial", ov16, 16'h0080);
    chk("t4 slot7 data", od16[63:56], 8'h77);
    or16 = 16'h0080;
    send(8'h3C, 0, 1, w);
    or16 = 0;
    chk("t4 waits", w, 0);
    chk("t4 all valid", ov16, 16'hFFFF);
    chk("t4 all data", od16, {16{8'h3C}});
    or16 = '1;
    @(posedge clock); #1;
    chk("t4 drained", ov16, 0);
    or16 = 0;
    // out-of-range on N=12
    sel12 = 13; v12 = 1;
    #1 chk("t5 ready oor", rdy12, 1);
    @(posedge clock); #1;
    v12 = 0;
    chk("t5 err pulse", err12, 1);
    chk("t5 count1", ec12, 1);
    chk("t5 no valid", ov12, 0);
    @(posedge clock); #1;
    chk("t5 err clear", err12, 0);
    chk("t5 count hold", ec12, 1);
    v12 = 1;
    repeat (300) @(posedge clock);
    #1 v12 = 0;
    chk("t5 count sat", ec12, 255);
    chk("t5 still empty", ov12, 0);
    d16 = 8'h9E; sel12 = 11; v12 = 1;
    #1 chk("t5 ready top ch", rdy12, 1);
    @(posedge clock); #1;
    v12 = 0;
    chk("t5 top ch valid", ov12, 12'h800);
    chk("t5 top ch data", od12[95:88], 8'h9E);
    chk("t5 no err", err12, 0);
    // asynchronous reset between edges
    send(8'h10, 0, 0, w);
    send(8'h11, 1, 0, w);
    send(8'h12, 2, 0, w);
    chk("t6 filled", ov16, 16'h0007);
    @(posedge clock); #3;
    reset_ = 0;
    for (int i = 0; i < 16; i++) q[i].delete();
    #1 chk("t6 async valid", ov16, 0);
    chk("t6 async data", od16, 0);
    #2 reset_ = 1;
    @(posedge clock); #1;
    send(8'hC3, 0, 0, w);
    chk("t6 waits", w, 0);
    chk("t6 valid", ov16, 16'h0001);
    chk("t6 data", od16[7:0], 8'hC3);
    or16 = '1;
    repeat (2) @(posedge clock);
    #1 tot = 0;
    for (int i = 0; i < 16; i++) tot += q[i].size();
    chk("scoreboard empty", tot, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
